// File: rtl/onewire_pkg.sv
// Shared types and default timing for the 1-Wire bus sequencer.
package onewire_pkg;

  typedef enum logic [1:0] {
    OW_RESET = 2'd0,
    OW_BIT   = 2'd1,
    OW_BYTE  = 2'd2,
    OW_NOP   = 2'd3
  } ow_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_RST_HIGH = 3'd2,
    ST_BIT_LOW  = 3'd3,
    ST_BIT_DRV  = 3'd4,
    ST_BIT_TAIL = 3'd5,
    ST_BIT_REC  = 3'd6,
    ST_DONE     = 3'd7
  } ow_state_e;

  // Standard-speed 1-Wire timing in microseconds.
  localparam int OW_T_RSTL = 480;
  localparam int OW_T_RSTH = 480;
  localparam int OW_T_RSTP = 75;
  localparam int OW_T_DAT0 = 60;
  localparam int OW_T_DAT1 = 5;
  localparam int OW_T_DATS = 15;
  localparam int OW_T_REC  = 5;

endpackage

// File: rtl/onewire_sequencer_if.sv
// Command/response channel between a host and the 1-Wire sequencer.
interface onewire_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_presence
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_presence
  );
endinterface

// File: rtl/onewire_timer.sv
// Loadable down-counter that times each sequencer phase.
// A phase of N cycles is loaded with N-1; done is high on its last cycle.
module onewire_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);

endmodule

// File: rtl/onewire_sequencer.sv
// 1-Wire master: issues reset/presence, single-bit and byte time slots.
// Every timed phase must be at least one microsecond long.
module onewire_sequencer
  import onewire_pkg::*;
#(
  parameter int CLK_PER_US = 50,
  parameter int T_RSTL     = OW_T_RSTL,
  parameter int T_RSTH     = OW_T_RSTH,
  parameter int T_RSTP     = OW_T_RSTP,
  parameter int T_DAT0     = OW_T_DAT0,
  parameter int T_DAT1     = OW_T_DAT1,
  parameter int T_DATS     = OW_T_DATS,
  parameter int T_REC      = OW_T_REC
) (
  input  logic                clk,
  input  logic                rst_n,
  onewire_sequencer_if.slave  bus,
  output logic                owr_oe,
  input  logic                owr_i
);

  localparam int CW = $clog2(T_RSTH * CLK_PER_US + 1);

  localparam logic [CW-1:0] LD_RSTL = CW'(T_RSTL * CLK_PER_US - 1);
  localparam logic [CW-1:0] LD_RSTH = CW'(T_RSTH * CLK_PER_US - 1);
  localparam logic [CW-1:0] LD_LOW  = CW'(T_DAT1 * CLK_PER_US - 1);
  localparam logic [CW-1:0] LD_DRV  = CW'((T_DATS - T_DAT1) * CLK_PER_US - 1);
  localparam logic [CW-1:0] LD_TAIL = CW'((T_DAT0 - T_DATS) * CLK_PER_US - 1);
  localparam logic [CW-1:0] LD_REC  = CW'(T_REC * CLK_PER_US - 1);
  // Counter value on the last cycle of the presence-sample window.
  localparam logic [CW-1:0] PRES_AT = CW'((T_RSTH - T_RSTP) * CLK_PER_US);

  ow_state_e state_q, state_d;
  ow_op_e    op_q, op_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] rd_q, rd_d;
  logic       pres_q, pres_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_pres_q, rsp_pres_d;
  logic       ready_q, ready_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_done;

  onewire_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .done     (tmr_done)
  );

  // Sequencer next-state, capture, sampling and response publication.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    bit_d      = bit_q;
    rd_d       = rd_q;
    pres_d     = pres_q;
    rsp_data_d = rsp_data_q;
    rsp_pres_d = rsp_pres_q;
    sync1_d    = owr_i;
    sync2_d    = sync1_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          op_d    = ow_op_e'(bus.cmd_op);
          wdata_d = bus.cmd_data;
          bit_d   = '0;
          case (ow_op_e'(bus.cmd_op))
            OW_RESET:        state_d = ST_RST_LOW;
            OW_BIT, OW_BYTE: state_d = ST_BIT_LOW;
            default:         state_d = ST_DONE;
          endcase
        end
      end
      ST_RST_LOW: begin
        if (tmr_done) state_d = ST_RST_HIGH;
      end
      ST_RST_HIGH: begin
        if (tmr_cnt == PRES_AT) pres_d = ~sync2_q;
        if (tmr_done) state_d = ST_DONE;
      end
      ST_BIT_LOW: begin
        if (tmr_done) state_d = ST_BIT_DRV;
      end
      ST_BIT_DRV: begin
        if (tmr_done) begin
          // LSB-first: each new sample enters at the top and shifts down.
          rd_d    = {sync2_q, rd_q[7:1]};
          state_d = ST_BIT_TAIL;
        end
      end
      ST_BIT_TAIL: begin
        if (tmr_done) state_d = ST_BIT_REC;
      end
      ST_BIT_REC: begin
        if (tmr_done) begin
          if (op_q == OW_BYTE && bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_BIT_LOW;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Results become visible together with the rsp_valid pulse.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      case (op_d)
        OW_RESET: rsp_pres_d = pres_d;
        OW_BIT:   rsp_data_d = {7'b0, rd_d[7]};
        OW_BYTE:  rsp_data_d = rd_d;
        default:  ;
      endcase
    end
  end

  // Load the phase timer whenever a new state is entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_RST_LOW:  tmr_val = LD_RSTL;
      ST_RST_HIGH: tmr_val = LD_RSTH;
      ST_BIT_LOW:  tmr_val = LD_LOW;
      ST_BIT_DRV:  tmr_val = LD_DRV;
      ST_BIT_TAIL: tmr_val = LD_TAIL;
      ST_BIT_REC:  tmr_val = LD_REC;
      default:     tmr_val = '0;
    endcase
    // Registered so that ready stays low while rst_n is asserted.
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; async reset releases the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OW_NOP;
      wdata_q    <= '0;
      bit_q      <= '0;
      rd_q       <= '0;
      pres_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_pres_q <= 1'b0;
      ready_q    <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      bit_q      <= bit_d;
      rd_q       <= rd_d;
      pres_q     <= pres_d;
      rsp_data_q <= rsp_data_d;
      rsp_pres_q <= rsp_pres_d;
      ready_q    <= ready_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  // Open-drain drive: pull low during reset/slot-start, write-0 keeps it low.
  always_comb begin
    owr_oe = 1'b0;
    case (state_q)
      ST_RST_LOW, ST_BIT_LOW:  owr_oe = 1'b1;
      ST_BIT_DRV, ST_BIT_TAIL: owr_oe = ~wdata_q[bit_q];
      default:                 owr_oe = 1'b0;
    endcase
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.rsp_valid    = (state_q == ST_DONE);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_presence = rsp_pres_q;

endmodule

// File: tb/tb_onewire_sequencer.sv
// Bench for onewire_sequencer at CLK_PER_US=1 with a pull-up and slave model.
module tb_onewire_sequencer;
  import onewire_pkg::*;

  localparam int TL = 480, TH = 480, D0 = 60, D1 = 5, TR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic owr_oe;
  logic owr_i;

  onewire_sequencer_if bus();

  onewire_sequencer #(.CLK_PER_US(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .owr_oe (owr_oe),
    .owr_i  (owr_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: answers a long reset pulse with a 100-cycle presence pulse
  // starting 20 cycles after release, and holds the bus low for 30 cycles
  // in every time slot whose bit is set in slave_mask.
  logic [7:0] slave_mask = 8'h00;
  logic       pres_en = 1'b0;
  int         p_start = -1000;
  int         pull_until = 0;
  int         slot_idx = 0;
  int         run = 0;
  logic       oe_prev = 1'b0;
  int         pulses[$];
  int         acc_cnt = 0;

  wire slave_low = ((cyc >= p_start) && (cyc < p_start + 100)) || (cyc < pull_until);
  assign owr_i = ~(owr_oe | slave_low);

  always @(posedge clk) begin
    oe_prev <= owr_oe;
    run <= owr_oe ? run + 1 : 0;
    if (!owr_oe && oe_prev) begin
      pulses.push_back(run);
      if (run >= 400 && pres_en) p_start <= cyc + 20;
    end
    if (bus.cmd_ready) begin
      slot_idx <= 0;
    end else if (owr_oe && !oe_prev) begin
      if (slave_mask[slot_idx[2:0]]) pull_until <= cyc + 30;
      slot_idx <= slot_idx + 1;
    end
    if (bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model.
  function automatic int model_lat(input logic [1:0] op);
    case (op)
      2'd0:    return TL + TH + 1;
      2'd1:    return D0 + TR + 1;
      2'd2:    return 8 * (D0 + TR) + 1;
      default: return 1;
    endcase
  endfunction

  function automatic int model_nbits(input logic [1:0] op);
    case (op)
      2'd1:    return 1;
      2'd2:    return 8;
      default: return 0;
    endcase
  endfunction

  // Issue one command, wait for its response; lat is accept-to-rsp cycles.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, output int lat, output int base);
    int a;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 3000) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) check("ready_timeout", 32'(bus.cmd_ready), 1);
    base = pulses.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    a = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = 8'($urandom);
    n = 0;
    while (!bus.rsp_valid && n < 3000) begin @(negedge clk); n++; end
    if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 1);
    lat = cyc - a;
  endtask

  // Bus drive widths: 480 for reset, 5 for write-1, 60 for write-0.
  task automatic check_pulses(input string name, input logic [1:0] op, input logic [7:0] d, input int base);
    int n;
    int bad;
    n = (op == 2'd0) ? 1 : model_nbits(op);
    check({name, " npulse"}, 32'(pulses.size() - base), 32'(n));
    if (pulses.size() - base == n) begin
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (op == 2'd0) begin
          if (pulses[base + i] != TL) bad++;
        end else if (pulses[base + i] != (d[i] ? D1 : D0)) begin
          bad++;
        end
      end
      check({name, " widths"}, 32'(bad), 0);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] m;
    logic       pe;
    logic [7:0] exp_data;
    logic       exp_pres;
    int         exp_lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat;
    int base;
    int a0;
    int bad;
    int n;
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] m;
    logic       pe;
    logic [7:0] m_data;
    logic       m_pres;

    tbl[0] = '{OW_RESET, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 961};
    tbl[1] = '{OW_BIT,   8'h01, 8'h00, 1'b0, 8'h01, 1'b1, 66};
    tbl[2] = '{OW_BIT,   8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 66};
    tbl[3] = '{OW_BYTE,  8'hA5, 8'h42, 1'b0, 8'hA5, 1'b1, 521};
    tbl[4] = '{OW_BYTE,  8'hFF, 8'h42, 1'b0, 8'hBD, 1'b1, 521};
    tbl[5] = '{OW_RESET, 8'h33, 8'h00, 1'b0, 8'hBD, 1'b0, 961};
    tbl[6] = '{OW_NOP,   8'h77, 8'h00, 1'b0, 8'hBD, 1'b0, 1};
    tbl[7] = '{OW_BIT,   8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 66};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst owr_oe", 32'(owr_oe), 0);
    check("rst cmd_ready", 32'(bus.cmd_ready), 0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst rsp_data", 32'(bus.rsp_data), 0);
    check("rst rsp_presence", 32'(bus.rsp_presence), 0);
    rst_n = 1'b1;
    #1 check("ready before clk", 32'(bus.cmd_ready), 0);
    @(posedge clk);
    #1 check("ready after clk", 32'(bus.cmd_ready), 1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      slave_mask = tbl[i].m;
      pres_en    = tbl[i].pe;
      do_cmd(tbl[i].op, tbl[i].d, lat, base);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("v%0d rsp_data", i), 32'(bus.rsp_data), 32'(tbl[i].exp_data));
      check($sformatf("v%0d rsp_presence", i), 32'(bus.rsp_presence), 32'(tbl[i].exp_pres));
      check_pulses($sformatf("v%0d", i), tbl[i].op, tbl[i].d, base);
      @(negedge clk);
      check($sformatf("v%0d rsp_valid pulse", i), 32'(bus.rsp_valid), 0);
      check($sformatf("v%0d ready back", i), 32'(bus.cmd_ready), 1);
    end

    // cmd_valid held through a whole BYTE.
    slave_mask = 8'h00;
    pres_en    = 1'b0;
    a0 = acc_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OW_BYTE;
    bus.cmd_data  = 8'h3C;
    @(negedge clk);
    bad = 0;
    n = 0;
    while (!bus.rsp_valid && n < 3000) begin
      if (bus.cmd_ready) bad++;
      @(negedge clk);
      n++;
    end
    check("hold rsp_valid", 32'(bus.rsp_valid), 1);
    check("hold ready at rsp", 32'(bus.cmd_ready), 0);
    check("hold ready low during op", 32'(bad), 0);
    check("hold rsp_data", 32'(bus.rsp_data), 32'h3C);
    @(negedge clk);
    check("hold ready after rsp", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b0;
    check("hold accept count", 32'(acc_cnt - a0), 1);

    // Reset 100 cycles into RST_LOW.
    pres_en = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OW_RESET;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (99) @(negedge clk);
    check("abort oe before", 32'(owr_oe), 1);
    #1 rst_n = 1'b0;
    #1 check("abort oe released", 32'(owr_oe), 0);
    check("abort ready", 32'(bus.cmd_ready), 0);
    bad = 0;
    repeat (5) begin @(negedge clk); if (bus.rsp_valid) bad++; end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (bus.rsp_valid) bad++; end
    check("abort no rsp", 32'(bad), 0);
    check("abort rsp_data cleared", 32'(bus.rsp_data), 0);
    do_cmd(OW_RESET, 8'h00, lat, base);
    check("after abort latency", 32'(lat), 961);
    check("after abort presence", 32'(bus.rsp_presence), 1);
    check_pulses("after abort", OW_RESET, 8'h00, base);
    m_data = 8'h00;
    m_pres = 1'b1;

    // Randomized commands against the reference model.
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      m  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      slave_mask = m;
      pres_en    = pe;
      do_cmd(op, d, lat, base);
      if (op == 2'd0) m_pres = pe;
      else if (op == 2'd1) m_data = {7'b0, d[0] & ~m[0]};
      else if (op == 2'd2) m_data = d & ~m;
      check($sformatf("r%0d op%0d latency", i, op), 32'(lat), 32'(model_lat(op)));
      check($sformatf("r%0d rsp_data", i), 32'(bus.rsp_data), 32'(m_data));
      check($sformatf("r%0d rsp_presence", i), 32'(bus.rsp_presence), 32'(m_pres));
      check_pulses($sformatf("r%0d", i), op, d, base);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onewire_sequencer.md
ONEWIRE_SEQUENCER -- requirements
Module: onewire_sequencer

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 50, meaning clock cycles per microsecond; all timing below is in microseconds times CLK_PER_US.
REQ-002 SHALL have parameters T_RSTL 480, T_RSTH 480, T_RSTP 75, T_DAT0 60, T_DAT1 5, T_DATS 15, T_REC 5: reset-low, reset-high, presence-sample, data-0 low, data-1 low, data-sample and recovery times in microseconds (integers).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_op  input  2  operation: 0 RESET, 1 BIT, 2 BYTE, 3 reserved (treated as a no-op).
REQ-008 SHALL have port cmd_data  input  8  write data; BIT uses bit 0; BYTE is sent LSB first.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle pulse on completion.
REQ-010 SHALL have port rsp_data  output  8  read data; BIT result in bit 0 with bits 7:1 zero; BYTE result LSB first.
REQ-011 SHALL have port rsp_presence  output  1  1 when a slave pulled the bus low at the RESET presence sample.
REQ-012 SHALL have port owr_oe  output  1  1 drives the bus low; 0 releases it (open drain).
REQ-013 SHALL have port owr_i  input  1  asynchronous bus level.

Function
REQ-014 SHALL synchronise owr_i through two flops; every bus sample uses the synchronised value.
REQ-015 SHALL implement the state machine IDLE, RST_LOW, RST_HIGH, BIT_LOW, BIT_DRV, BIT_TAIL, BIT_REC, DONE, using one down-counter loaded on each state entry.
REQ-016 SHALL assert cmd_ready only in IDLE, and SHALL accept a command on a handshake: RESET goes to RST_LOW, BIT or BYTE goes to BIT_LOW, reserved goes to DONE.
REQ-017 RST_LOW SHALL hold owr_oe=1 for T_RSTL.
REQ-018 RST_HIGH SHALL hold owr_oe=0 for T_RSTH, and SHALL latch rsp_presence = ~sync(owr_i) on the cycle that ends T_RSTP in that state.
REQ-019 BIT_LOW SHALL hold owr_oe=1 for T_DAT1.
REQ-020 BIT_DRV SHALL drive owr_oe = ~wbit for T_DATS-T_DAT1, then sample sync(owr_i) into the read shift register on its last cycle.
REQ-021 BIT_TAIL SHALL keep the BIT_DRV value of owr_oe for T_DAT0-T_DATS.
REQ-022 BIT_REC SHALL hold owr_oe=0 for T_REC.
REQ-023 On leaving BIT_REC, a BYTE command with bit index <7 SHALL increment the index and return to BIT_LOW; otherwise the block SHALL go to DONE.
REQ-024 DONE SHALL pulse rsp_valid for one cycle with rsp_data valid, then return to IDLE.
REQ-025 rsp_data and rsp_presence SHALL hold their values until the next completion; RESET SHALL leave rsp_data unchanged, and BIT/BYTE SHALL leave rsp_presence unchanged.
REQ-026 Each timed phase SHALL last exactly its time multiplied by CLK_PER_US cycles; the counter width is $clog2(T_RSTH*CLK_PER_US+1).
REQ-027 Commands offered while not in IDLE SHALL NOT be accepted, and cmd_op and cmd_data SHALL be captured at acceptance.

Reset
REQ-028 While rst_n=0 the block SHALL force state IDLE, owr_oe=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_presence=0, synchroniser flops=1 and counter=0.
REQ-029 cmd_ready SHALL rise on the first clock after rst_n is deasserted.
REQ-030 A reset mid-operation SHALL abort the operation with no response and release the bus immediately.

Structure
REQ-031 Package onewire_pkg SHALL hold the cmd_op enum (OW_RESET, OW_BIT, OW_BYTE, OW_NOP), the state enum and the default microsecond timing constants.
REQ-032 Sub-module onewire_timer SHALL be the loadable down-counter with a "done" output; everything else stays in one FSM.

Verification (CLK_PER_US=1, slave model on the bus with pull-up)
REQ-033 RESET accepted at cycle 0 with a slave pulling low from cycle 500 to 600 -> owr_oe high for cycles 1-480, rsp_presence=1, and rsp_valid at 480+480+1±1.
REQ-034 RESET with no slave -> rsp_presence=0, and rsp_data is unchanged from its prior value.
REQ-035 BIT with cmd_data=1 and an idle bus -> owr_oe low-pulse 5 cycles, slot 65 cycles, rsp_data=8'h01. BIT with cmd_data=0 -> owr_oe high 60 cycles, rsp_data=8'h00.
REQ-036 BYTE with cmd_data=8'hA5 and a slave holding bits 1 and 6 low -> bus low-pulse widths 5,60,5,60,60,5,60,5, rsp_data=8'hA5&~8'h42=8'hA5, total 520 cycles+overhead; repeat with 8'hFF -> rsp_data=8'hBD.
REQ-037 cmd_valid held high throughout a BYTE -> exactly one acceptance, and cmd_ready=0 until the cycle after rsp_valid.
REQ-038 rst_n pulled low 100 cycles into RST_LOW -> owr_oe=0 within the same cycle, no rsp_valid, and the next RESET behaves as in REQ-033.
